// File: rtl/bin2bcd_7seg_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_7seg_scan_if
//  Description : Conversion handshake and display bus for bin2bcd_7seg_scan.
//                The master side requests conversions and watches the display.
//                The slave side is the converter/scanner itself.
//  Revision    : 1.0  initial release
// ============================================================================
interface bin2bcd_7seg_scan_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [6:0]            seg;
    logic [DIGITS-1:0]     an;

    modport master (
        output start, bin,
        input  busy, done, bcd, seg, an
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, seg, an
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_7seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : bin2bcd_7seg_scan
//  Description : Sequential double-dabble binary-to-BCD converter with a
//                start/busy/done handshake, plus a free-running multiplexed
//                scan of the BCD digits onto an active-low 7-segment bus.
//                Optional macro LEADING_ZERO_BLANK_EN blanks leading zero
//                digits (digit 0 always shown).
//  Revision    : 1.0  initial release
// ============================================================================
module bin2bcd_7seg_scan #(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 3,
    parameter int REFRESH_DIV = 50000
) (
    input  logic               clk2,
    input  logic               rst,
    bin2bcd_7seg_scan_if.slave bus
);

    localparam int c_CNT_W = $clog2(WIDTH + 1);
    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DIGITS - 1);

    localparam longint unsigned c_MAX_BIN = (64'd1 << WIDTH) - 64'd1;
    localparam longint unsigned c_MAX_DEC = 64'd10 ** DIGITS;

    // Reject configurations whose digit count cannot hold the largest input.
    if (c_MAX_DEC <= c_MAX_BIN) begin : g_param_check
        $error("bin2bcd_7seg_scan: DIGITS too small for WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_shift;
    logic [c_BCD_W-1:0]   r_scratch;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic [c_BCD_W-1:0]   r_bcd;

    logic [c_REF_W-1:0]   r_refresh;
    logic [c_IDX_W-1:0]   r_idx;
    logic [6:0]           r_seg;
    logic [DIGITS-1:0]    r_an;

    logic [c_BCD_W-1:0]   w_adj;
    logic [3:0]           w_digit;
    logic [DIGITS-1:0]    w_an_n;
    logic                 w_blank;

    // Active-low segment pattern {g,f,e,d,c,b,a}; non-decimal nibbles are blank.
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Add-3 correction on every scratch nibble that would overflow after doubling.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM: capture in IDLE, WIDTH add-then-shift steps, publish in DONE.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_shift   <= bus.bin;
                        r_scratch <= '0;
                        r_cnt     <= c_CNT_LOAD;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    {r_scratch, r_shift} <= {w_adj, r_shift} << 1;
                    r_cnt <= r_cnt - c_CNT_ONE;
                    if (r_cnt == c_CNT_ONE) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_bcd   <= r_scratch;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Refresh divider and scan index; free-running, independent of the FSM.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            r_refresh <= '0;
            r_idx     <= '0;
        end else if (r_refresh == c_REF_LAST) begin
            r_refresh <= '0;
            r_idx     <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
        end else begin
            r_refresh <= r_refresh + c_REF_W'(1);
        end
    end

    // Select the digit under the scan index and build its active-low enable.
    always_comb begin
        w_digit = 4'd0;
        w_an_n  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_digit   = r_bcd[4*i +: 4];
                w_an_n[i] = 1'b0;
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // w_zero_from[i] is set when digit i and every digit above it are zero.
    logic [DIGITS:1] w_zero_from;
    assign w_zero_from[DIGITS] = 1'b1;

    for (genvar g = 1; g < DIGITS; g++) begin : g_lzb
        assign w_zero_from[g] = (r_bcd[4*g +: 4] == 4'd0) && w_zero_from[g+1];
    end

    // Blank the scanned digit if it is a leading zero; digit 0 always shows.
    always_comb begin
        w_blank = 1'b0;
        for (int i = 1; i < DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_blank = w_zero_from[i];
            end
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    // Registered display drive, one cycle behind the index/bcd it reflects.
    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            r_seg <= 7'b1111111;
            r_an  <= '1;
        end else begin
            r_seg <= w_blank ? 7'b1111111 : f_decode(w_digit);
            r_an  <= w_an_n;
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.bcd  = r_bcd;
    assign bus.seg  = r_seg;
    assign bus.an   = r_an;

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_7seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin2bcd_7seg_scan
//  Description : Directed, table-driven bench for bin2bcd_7seg_scan
//                (WIDTH=8, DIGITS=3, REFRESH_DIV=2). Display expectations
//                follow LEADING_ZERO_BLANK_EN when it is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bin2bcd_7seg_scan;

    localparam int c_WIDTH  = 8;
    localparam int c_DIGITS = 3;

    localparam logic [6:0] c_S0    = 7'b1000000;
    localparam logic [6:0] c_S2    = 7'b0100100;
    localparam logic [6:0] c_S5    = 7'b0010010;
    localparam logic [6:0] c_S7    = 7'b1111000;
    localparam logic [6:0] c_BLANK = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] c_LZ = c_BLANK;
`else
    localparam logic [6:0] c_LZ = c_S0;
`endif

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
    } vec_t;

    logic clk2 = 1'b0;
    logic rst  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bin2bcd_7seg_scan_if #(.WIDTH(c_WIDTH), .DIGITS(c_DIGITS)) bus ();

    bin2bcd_7seg_scan #(
        .WIDTH(c_WIDTH),
        .DIGITS(c_DIGITS),
        .REFRESH_DIV(2)
    ) dut (
        .clk2(clk2),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk2 = ~clk2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk2);
        #1;
    endtask

    // Full conversion with latency, busy width, hold and single-pulse checks.
    task automatic convert(input logic [7:0] b, input logic [11:0] exp, input string name);
        int n;
        int busy_cycles;
        logic got;
        logic held_ok;
        logic [11:0] prev;
        prev = bus.bcd;
        bus.start = 1'b1;
        bus.bin   = b;
        step();
        bus.start = 1'b0;
        check({name, "_busy_rise"}, 32'(bus.busy), 32'd1);
        n = 0; busy_cycles = 1; got = 1'b0; held_ok = 1'b1;
        while (!got && n < 40) begin
            step();
            n++;
            if (bus.done) got = 1'b1;
            else begin
                if (bus.busy) busy_cycles++;
                if (bus.bcd !== prev) held_ok = 1'b0;
            end
        end
        check({name, "_latency"}, got ? 32'(n) : 32'hFFFF, 32'(c_WIDTH + 1));
        check({name, "_busy_cycles"}, 32'(busy_cycles), 32'(c_WIDTH + 1));
        check({name, "_held"}, 32'(held_ok), 32'd1);
        check({name, "_bcd"}, 32'(bus.bcd), 32'(exp));
        step();
        check({name, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    endtask

    // Align to the start of the units window, then check two-cycle dwell and order.
    task automatic scan_check(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input string name);
        logic [6:0] es [3];
        logic [2:0] ea [3];
        logic [2:0] prev;
        logic found;
        int idx;
        es[0] = s0; es[1] = s1; es[2] = s2;
        ea[0] = 3'b110; ea[1] = 3'b101; ea[2] = 3'b011;
        found = 1'b0;
        prev = bus.an;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (bus.an == 3'b110 && prev != 3'b110) found = 1'b1;
            prev = bus.an;
        end
        check({name, "_sync"}, 32'(found), 32'd1);
        for (int j = 0; j < 8; j++) begin
            if (j > 0) step();
            idx = (j / 2) % 3;
            check($sformatf("%s_an%0d", name, j), 32'(bus.an), 32'(ea[idx]));
            check($sformatf("%s_seg%0d", name, j), 32'(bus.seg), 32'(es[idx]));
        end
    endtask

    initial begin
        vec_t vecs [9];
        int dones;
        logic [11:0] first_bcd;

        vecs[0] = '{8'd255, 12'h255};
        vecs[1] = '{8'd0,   12'h000};
        vecs[2] = '{8'd128, 12'h128};
        vecs[3] = '{8'd99,  12'h099};
        vecs[4] = '{8'd7,   12'h007};
        vecs[5] = '{8'd1,   12'h001};
        vecs[6] = '{8'd100, 12'h100};
        vecs[7] = '{8'd9,   12'h009};
        vecs[8] = '{8'd10,  12'h010};

        bus.start = 1'b0;
        bus.bin   = '0;

        // Reset state
        repeat (2) step();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bcd",  32'(bus.bcd),  32'd0);
        check("rst_an",   32'(bus.an),   32'b111);
        check("rst_seg",  32'(bus.seg),  32'(c_BLANK));
        rst = 1'b0;
        step();

        // Table-driven conversions
        for (int i = 0; i < 9; i++) begin
            convert(vecs[i].bin, vecs[i].bcd, $sformatf("vec%0d", i));
        end

        // Start during a running conversion is ignored; bin changes do not matter
        bus.start = 1'b1;
        bus.bin   = 8'd42;
        step();
        bus.start = 1'b0;
        step();
        step();
        bus.start = 1'b1;
        bus.bin   = 8'd200;
        step();
        bus.start = 1'b0;
        bus.bin   = 8'd77;
        dones = 0;
        first_bcd = 12'hFFF;
        for (int k = 0; k < 30; k++) begin
            step();
            if (bus.done) begin
                dones++;
                if (dones == 1) first_bcd = bus.bcd;
            end
        end
        check("ignore_done_count", 32'(dones), 32'd1);
        check("ignore_bcd", 32'(first_bcd), 32'h042);

        // Asynchronous reset mid-SHIFT aborts the conversion
        bus.start = 1'b1;
        bus.bin   = 8'd255;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_bcd",  32'(bus.bcd),  32'd0);
        check("midrst_an",   32'(bus.an),   32'b111);
        check("midrst_seg",  32'(bus.seg),  32'(c_BLANK));
        #2;
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (bus.done) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        convert(8'd123, 12'h123, "post_rst");

        // Scan order and dwell with bcd = 205
        convert(8'd205, 12'h205, "scan205");
        scan_check(c_S5, c_S0, c_S2, "scan205");

        // Leading-zero handling
        convert(8'd7, 12'h007, "lz7");
        scan_check(c_S7, c_LZ, c_LZ, "lz7");
        convert(8'd0, 12'h000, "lz0");
        scan_check(c_S0, c_LZ, c_LZ, "lz0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bin2bcd_7seg_scan.md
Name: bin2bcd_7seg_scan

Overview:
Parametrised successor to the 4-bit BCD/7-segment decoder stage. Converts an unsigned binary word to packed BCD using a sequential shift-and-add-3 (double-dabble) engine with a start/busy/done handshake. Time-multiplexes the resulting DIGITS decimal digits onto a shared 7-segment bus. Sits between the lab's switch/counter sources and the board's multiplexed common-anode display.

Parameters:
WIDTH, 8, binary input width in bits (>= 1)
DIGITS, 3, number of BCD digits / display positions; must satisfy 10^DIGITS > 2^WIDTH - 1 (elaboration-time check required)
REFRESH_DIV, 50000, clk2 cycles each digit stays enabled before the scan advances (>= 1)

Ports:
clk2  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  conversion request, sampled in IDLE only
bin  input  WIDTH  binary value, captured on the accepted start edge
busy  output  1  high while a conversion is in progress
done  output  1  single-cycle pulse when bcd has been updated
bcd  output  4*DIGITS  last converted result, digit 0 (units) in bits [3:0]
seg  output  7  segment drive, active-low, order {g,f,e,d,c,b,a}
an  output  DIGITS  digit enables, active-low, an[0] = units digit

Behaviour:
- Reset (asynchronous, takes effect immediately, overrides everything): FSM=IDLE, busy=0, done=0, bcd=0, shift/scratch registers=0, iteration counter=0, scan index=0, refresh counter=0, an=all ones, seg=7'b1111111.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE: on an edge with start=1, capture bin into the shift register, clear the BCD scratch, load the iteration counter with WIDTH, and go to SHIFT. busy rises on that edge.
- SHIFT: each cycle, every scratch nibble >= 5 gets +3, then {scratch, shift} shifts left by 1 (add-then-shift within one cycle). Decrement the counter. When the counter reaches 0 after WIDTH cycles, go to DONE.
- DONE: on that edge, copy scratch to bcd, set done=1 and busy=0, return to IDLE. done is high for exactly one cycle.
- Latency: start accepted at edge k -> busy=1 from k through k+WIDTH -> bcd valid and done=1 after edge k+WIDTH+1.
- start while busy (SHIFT/DONE) is ignored, not queued. start held high continuously produces back-to-back conversions, with one IDLE cycle between them.
- bin changes after capture do not affect the running conversion.
- bcd holds its previous value throughout a conversion, so the display never shows partial results.
- Reset mid-conversion aborts the conversion: bcd=0, no done pulse.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1. On wrap, the scan index advances, wrapping DIGITS-1 -> 0.
  - seg and an are registered: one cycle after the index/bcd change, an has a single 0 at the index position, and seg shows that digit's pattern.
  - The scan free-runs independent of the FSM.
- Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Nibbles 10-15 give blank (1111111); these cannot occur from the engine.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: a digit at position i>0 is blanked (seg=1111111, an still asserted) when it and all higher digits are 0. Digit 0 is never blanked, so the value 0 displays "0".
- Undefined: all digits are shown, including leading zeros. bcd is unaffected in both cases.

Test Plan:
1. WIDTH=8, DIGITS=3: bin=255, start pulse -> busy high 9 cycles, done pulse once, bcd=12'h255.
2. bin=0 -> bcd=12'h000. bin=128 -> bcd=12'h128. bin=99 -> bcd=12'h099; verify each done arrives exactly WIDTH+1 edges after start.
3. start pulsed at cycle 3 of a running conversion with a different bin -> ignored; bcd reflects the first bin and only one done is produced.
4. rst asserted mid-SHIFT -> busy=0, bcd=0, an=111, seg=1111111 immediately; no done follows; a new start converts correctly.
5. REFRESH_DIV=2, bcd=12'h205 -> an cycles 110,101,011,110 every 2 cycles with seg 0010010, 1000000, 0100100 respectively.
6. With LEADING_ZERO_BLANK_EN: bin=7 -> digits 2 and 1 show 1111111, digit 0 shows 1111000. bin=0 -> digit 0 shows 1000000. Without the macro: digits 2 and 1 show 1000000.
